// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty sequencer.
package pwm_pkg;

  localparam int unsigned DUTY_W           = 4;
  localparam int unsigned DUTY_MAX_DEFAULT = 10;

  typedef enum logic [2:0] {
    MANUAL    = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_TOP  = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_BOT  = 3'd4
  } state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Step-tick generator: one-cycle tick every STEP_TICKS enabled cycles, counter held at 0 when disabled.
module pwm_tick_gen #(
  parameter int unsigned STEP_TICKS = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-step sequencer: manual inc/dec or automatic triangle ramp with end-point dwell;
// the applied duty only follows the target at PWM period boundaries.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_MAX   = DUTY_MAX_DEFAULT,
  parameter int unsigned STEP_TICKS = 25000000,
  parameter int unsigned HOLD_STEPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              ramp_en,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic [2:0]        state
);

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DMID = DUTY_W'(DUTY_MAX / 2);
  localparam logic [DUTY_W-1:0] ONE  = DUTY_W'(1);
  localparam int unsigned       HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [DUTY_W-1:0]   applied_q, applied_d;
  logic                upd_q, upd_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                ramp_en_q;
  logic                tick;

  pwm_tick_gen #(
    .STEP_TICKS(STEP_TICKS)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ramp_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    hold_d    = hold_q;
    // Applied register samples the pre-tick target, so a coinciding tick waits a period.
    applied_d = period_end ? target_q : applied_q;
    upd_d     = period_end && (target_q != applied_q);

    case (state_q)
      MANUAL: begin
        if (inc_pulse && !dec_pulse && (target_q < DMAX)) begin
          target_d = target_q + ONE;
        end else if (dec_pulse && !inc_pulse && (target_q != '0)) begin
          target_d = target_q - ONE;
        end
        if (ramp_en && !ramp_en_q) begin
          hold_d  = '0;
          state_d = (target_d == DMAX) ? HOLD_TOP : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          if (target_q >= DMAX - ONE) begin
            target_d = DMAX;
            hold_d   = '0;
            state_d  = HOLD_TOP;
          end else begin
            target_d = target_q + ONE;
          end
        end
      end
      HOLD_TOP: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = RAMP_DOWN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          if (target_q <= ONE) begin
            target_d = '0;
            hold_d   = '0;
            state_d  = HOLD_BOT;
          end else begin
            target_d = target_q - ONE;
          end
        end
      end
      HOLD_BOT: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = RAMP_UP;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = MANUAL;
        hold_d  = '0;
      end
    endcase

    if ((state_q != MANUAL) && !ramp_en) begin
      state_d  = MANUAL;
      target_d = target_q;
      hold_d   = '0;
    end
  end

  // ramp_en_q resets high so a ramp_en already high at release is not taken as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MANUAL;
      target_q  <= DMID;
      applied_q <= DMID;
      upd_q     <= 1'b0;
      hold_q    <= '0;
      ramp_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      upd_q     <= upd_d;
      hold_q    <= hold_d;
      ramp_en_q <= ramp_en;
    end
  end

  assign duty     = applied_q;
  assign duty_upd = upd_q;
  assign state    = state_q;

endmodule
